// File: rtl/conv_result_buffer_pkg.sv
`default_nettype none
// ============================================================================
// conv_pkg : default widths, output limits and the per-channel post-process.
// Rev 1.0
// ============================================================================
package conv_pkg;

    localparam int DEF_ACC_W   = 20;
    localparam int DEF_OUT_W   = 8;
    localparam int DEF_SHIFT_W = 5;
    localparam int MAX_W       = 64;

    localparam logic signed [DEF_OUT_W-1:0] OUT_MAX = {1'b0, {(DEF_OUT_W-1){1'b1}}};
    localparam logic signed [DEF_OUT_W-1:0] OUT_MIN = {1'b1, {(DEF_OUT_W-1){1'b0}}};
    localparam logic signed [MAX_W:0]       ONE     = {{MAX_W{1'b0}}, 1'b1};

    // acc arrives sign-extended to MAX_W, so the rounding add has headroom
    // for any accumulator narrower than MAX_W. Returns {sat, result}.
    function automatic logic [MAX_W:0] round_shift_sat(
        input logic signed [MAX_W-1:0] acc,
        input logic [31:0]             shift,
        input logic                    relu,
        input int                      out_w
    );
        logic signed [MAX_W:0] r;
        logic signed [MAX_W:0] hi;
        logic signed [MAX_W:0] lo;
        logic                  sat;
        r = {acc[MAX_W-1], acc};
        if (shift != 32'd0) begin
            r = (r + (ONE <<< (shift - 32'd1))) >>> shift;
        end
        if (relu && r[MAX_W]) begin
            r = '0;
        end
        hi  = (ONE <<< (out_w - 1)) - ONE;
        lo  = ~hi;
        sat = 1'b0;
        if (r > hi) begin
            r   = hi;
            sat = 1'b1;
        end else if (r < lo) begin
            r   = lo;
            sat = 1'b1;
        end
        return {sat, r[MAX_W-1:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_result_buffer_if.sv
`default_nettype none
// ============================================================================
// conv_result_buffer_if : load, config and serialized output bundle.
// Rev 1.0
// ============================================================================
interface conv_result_buffer_if
    import conv_pkg::*;
#(
    parameter int ACC_W   = DEF_ACC_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int NUM_CH  = 4,
    parameter int DEPTH   = 4,
    parameter int SHIFT_W = DEF_SHIFT_W
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_CH*ACC_W-1:0] acc_in;
    logic                    load_valid;
    logic                    load_ready;
    logic [SHIFT_W-1:0]      cfg_shift;
    logic                    cfg_relu;
    logic                    flush;
    logic                    clr_sat;
    logic [OUT_W-1:0]        out_data;
    logic [CH_W-1:0]         out_ch;
    logic                    out_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [CNT_W-1:0]        count;
    logic                    sat_flag;

    modport master (
        output acc_in, load_valid, cfg_shift, cfg_relu, flush, clr_sat, out_ready,
        input  load_ready, out_data, out_ch, out_last, out_valid, count, sat_flag
    );

    modport slave (
        input  acc_in, load_valid, cfg_shift, cfg_relu, flush, clr_sat, out_ready,
        output load_ready, out_data, out_ch, out_last, out_valid, count, sat_flag
    );

endinterface
`default_nettype wire

// File: rtl/conv_result_buffer_acc_postproc.sv
`default_nettype none
// ============================================================================
// acc_postproc : rounding shift, optional ReLU and saturation for one channel.
// Rev 1.0
// ============================================================================
module acc_postproc
    import conv_pkg::*;
#(
    parameter int ACC_W   = DEF_ACC_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input  wire [ACC_W-1:0]   acc_i,
    input  wire [SHIFT_W-1:0] shift_i,
    input  wire               relu_i,
    output logic [OUT_W-1:0]  result_o,
    output logic              sat_o
);

    logic signed [MAX_W-1:0] w_acc_ext;
    logic [MAX_W:0]          w_ret;
    logic                    w_unused_hi;

    assign w_acc_ext = {{(MAX_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
    assign w_ret     = round_shift_sat(w_acc_ext, 32'(shift_i), relu_i, OUT_W);
    assign result_o  = w_ret[OUT_W-1:0];
    assign sat_o     = w_ret[MAX_W];
    // Upper result bits are only sign extension once saturated to OUT_W.
    assign w_unused_hi = ^w_ret[MAX_W-1:OUT_W];

endmodule
`default_nettype wire

// File: rtl/conv_result_buffer.sv
`default_nettype none
// ============================================================================
// conv_result_buffer : per-channel post-process, vector FIFO, beat serializer.
// Rev 1.0
// ============================================================================
module conv_result_buffer
    import conv_pkg::*;
#(
    parameter int ACC_W   = DEF_ACC_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int NUM_CH  = 4,
    parameter int DEPTH   = 4,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input wire clk,
    input wire rst,
    conv_result_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = PTR_W + 1;
    localparam int VEC_W = NUM_CH * OUT_W;

    logic [VEC_W-1:0]  w_proc_vec;
    logic [NUM_CH-1:0] w_sat_vec;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            acc_postproc #(
                .ACC_W   (ACC_W),
                .OUT_W   (OUT_W),
                .SHIFT_W (SHIFT_W)
            ) u_pp (
                .acc_i    (bus.acc_in[c*ACC_W +: ACC_W]),
                .shift_i  (bus.cfg_shift),
                .relu_i   (bus.cfg_relu),
                .result_o (w_proc_vec[c*OUT_W +: OUT_W]),
                .sat_o    (w_sat_vec[c])
            );
        end
    endgenerate

    logic [VEC_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CH_W-1:0]  ch_idx_q, ch_idx_d;
    logic             sat_q, sat_d;

    logic             w_load_ready;
    logic             w_push;
    logic             w_out_valid;
    logic             w_last;
    logic             w_beat;
    logic             w_pop;
    logic [VEC_W-1:0] w_head;

    // Full is judged on the stored count only, so a pop never frees a slot
    // for a push in the same cycle.
    assign w_load_ready = (count_q != CNT_W'(DEPTH));
    assign w_push       = bus.load_valid && w_load_ready && !bus.flush;
    assign w_out_valid  = (count_q != '0);
    assign w_last       = w_out_valid && (ch_idx_q == CH_W'(NUM_CH - 1));
    assign w_beat       = w_out_valid && bus.out_ready;
    assign w_pop        = w_beat && w_last;
    assign w_head       = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ch_idx_d = ch_idx_q;
        sat_d    = sat_q;
        if (bus.clr_sat) begin
            sat_d = 1'b0;
        end
        if (w_push && (|w_sat_vec)) begin
            sat_d = 1'b1;
        end
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ch_idx_d = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
            end
            if (w_push && !w_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                count_d = count_q - CNT_W'(1);
            end
            if (w_beat) begin
                ch_idx_d = w_last ? '0 : ch_idx_q + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ch_idx_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ch_idx_q <= ch_idx_d;
            sat_q    <= sat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= w_proc_vec;
        end
    end

    assign bus.load_ready = w_load_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_last   = w_last;
    assign bus.out_ch     = ch_idx_q;
    assign bus.out_data   = w_out_valid ? w_head[ch_idx_q*OUT_W +: OUT_W] : '0;
    assign bus.count      = count_q;
    assign bus.sat_flag   = sat_q;

endmodule
`default_nettype wire

// File: doc/conv_result_buffer.md
Name: conv_result_buffer

Overview:
Parametrised successor to the single-channel accumulator result register. It captures NUM_CH accumulator results in parallel and post-processes each one: rounding right-shift, optional ReLU, then saturation to OUT_W. Vectors are buffered in a DEPTH-entry FIFO and streamed out one channel per beat over a valid/ready handshake. It sits between the convolution MAC/accumulator array and the output write-back path.

Parameters:
ACC_W, 20, accumulator width (signed two's complement)
OUT_W, 8, output pixel width (signed)
NUM_CH, 4, parallel channels per load
DEPTH, 4, FIFO depth in vectors; power of 2, >=2
SHIFT_W, 5, width of cfg_shift

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
acc_in  in  NUM_CH*ACC_W  channel c at bits [c*ACC_W +: ACC_W]
load_valid  in  1  acc_in valid
load_ready  out  1  buffer can accept a vector
cfg_shift  in  SHIFT_W  right-shift amount, 0..ACC_W-1
cfg_relu  in  1  clamp negatives to 0
flush  in  1  synchronous discard of all buffered data
clr_sat  in  1  clear sticky saturation flag
out_data  out  OUT_W  current channel result
out_ch  out  $clog2(NUM_CH)  channel index of out_data
out_last  out  1  final channel of the vector
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts beat
count  out  $clog2(DEPTH)+1  vectors stored
sat_flag  out  1  sticky: any channel saturated

Behaviour:
- Reset (rst==0 at posedge): wr/rd pointers 0, ch_idx 0, count 0, sat_flag 0. Hence out_valid=0, load_ready=1, out_ch=0, out_last=0, and out_data=0 (forced to 0 when empty).
- Push: load_valid && load_ready. load_ready = (count != DEPTH); it does not depend on out_ready, so there is no push while full, even if a pop happens in the same cycle.
- Post-processing is applied per channel at push time, using the cfg values sampled that cycle. cfg changes never affect already-stored data.
  - Round: if shift>0, compute r = (acc + (1<<(shift-1))) >>> shift, with arithmetic shift and ACC_W+1 internal width so the add cannot overflow. If shift=0, r = acc.
  - ReLU: if cfg_relu and r<0, r = 0.
  - Saturate: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. If a clamp occurs on any channel of a pushed vector, sat_flag is set the next cycle.
- sat_flag: sticky. clr_sat clears it, but a same-cycle set wins.
- Latency: a vector pushed in cycle N gives out_valid=1 in cycle N+1 if the FIFO was empty. There is no combinational fall-through.
- Output serializer:
  - out_valid = (count != 0).
  - out_data = head[ch_idx]; out_ch = ch_idx; out_last = (ch_idx == NUM_CH-1) && out_valid.
  - On out_valid && out_ready: if out_last, pop the head and set ch_idx=0; otherwise ch_idx++.
  - Stalls (out_ready=0) hold out_data, out_ch and out_last stable.
- Simultaneous push and final-beat pop: count is unchanged and pointers advance independently. Wrap-around uses pointers with an extra MSB; full/empty are derived from count.
- flush: same-cycle effect at the next edge. Pointers, count and ch_idx go to 0; a push in the same cycle is discarded; sat_flag is unaffected. rst has priority over flush.
- Reset or flush mid-vector (ch_idx != 0) abandons the partial vector.
- Priority: rst > flush > push/pop.

Decomposition:
- Package conv_pkg:
  - ACC_W/OUT_W defaults
  - saturating-limit constants derived from OUT_W
  - function round_shift_sat(acc, shift, relu), returning {sat, result}
- Sub-module acc_postproc: combinational, one instance per channel via generate. Output is result[OUT_W-1:0] and sat.
- FIFO storage and serializer stay in conv_result_buffer.

Test Plan:
Defaults used throughout: ACC_W=20, OUT_W=8, NUM_CH=4, DEPTH=4.
- Rounding: shift=4, relu=0, acc_in all channels = 291 (0x00123) -> out beats 18,18,18,18. out_ch 0..3, out_last on beat 4, first out_valid 1 cycle after push, sat_flag=0.
- Saturation: shift=0, channels {0x7FFFF, 0xFFC18 (-1000), 127, -128} -> out 127, -128 (0x80), 127, -128. sat_flag=1 and stays 1 until clr_sat.
- ReLU and negative rounding: relu=1, shift=1, channels {-5, 5, -1, 0} -> 0, 3, 0, 0. With relu=0 the same vector gives -2, 3, 0, 0 (round half up), sat_flag=0.
- Full/backpressure: out_ready=0, push 4 vectors (values 1..4, shift=0).
  - load_ready=0 after the 4th push, count=4.
  - A 5th load_valid is held, not accepted.
  - Then out_ready=1 for 16 beats: data 1,1,1,1,2,...,4, out_last on beats 4/8/12/16; load_ready returns to 1 the cycle after beat 4.
  - Toggling out_ready every cycle gives identical data ordering.
- Concurrent push/pop at count=1: push in the same cycle as the final-beat pop -> count stays 1, next vector's ch0 appears the next cycle, no beat lost or duplicated.
- Flush/reset mid-vector: after 2 beats of a vector, assert flush with load_valid=1 -> count=0, out_valid=0, ch_idx=0, pushed vector discarded. Repeat with rst=0 -> sat_flag also 0.
